// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - PS ureg group address constants shared with the ureg decoder
package ps_pkg;

    localparam logic [4:0] PCSTK  = 5'h04;
    localparam logic [4:0] PCSTKP = 5'h05;

endpackage

// File: rtl/ps_pcstk_if.sv
// rtl/ps_pcstk_if.sv - decoder/sequencer to PC stack signal bundle
interface ps_pcstk_if #(
    parameter int DW = 16
);

    logic          ps_pshstck;
    logic          ps_popstck;
    logic [4:0]    ps_rd_add;
    logic          ps_wrt_en;
    logic [4:0]    ps_wrt_add;
    logic [DW-1:0] ps_wrt_dat;
    logic          ps_sq_push;
    logic [DW-1:0] ps_sq_pc;
    logic          ps_sq_pop;
    logic [DW-1:0] ps_rd_dat;
    logic [DW-1:0] ps_stk_top;
    logic          ps_stk_empty;
    logic          ps_stk_full;
    logic          ps_stk_ovf;
    logic          ps_stk_unf;

    modport master (
        output ps_pshstck, ps_popstck, ps_rd_add, ps_wrt_en, ps_wrt_add, ps_wrt_dat,
        output ps_sq_push, ps_sq_pc, ps_sq_pop,
        input  ps_rd_dat, ps_stk_top, ps_stk_empty, ps_stk_full, ps_stk_ovf, ps_stk_unf
    );

    modport slave (
        input  ps_pshstck, ps_popstck, ps_rd_add, ps_wrt_en, ps_wrt_add, ps_wrt_dat,
        input  ps_sq_push, ps_sq_pc, ps_sq_pop,
        output ps_rd_dat, ps_stk_top, ps_stk_empty, ps_stk_full, ps_stk_ovf, ps_stk_unf
    );

endinterface

// File: rtl/ps_pcstk_mem.sv
// rtl/ps_pcstk_mem.sv - PC stack entry array, one write port, one async read port
module ps_pcstk_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdat,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdat
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wadr] <= wdat;
        end
    end

    assign rdat = mem[radr];

endmodule

// File: rtl/ps_pcstk.sv
// rtl/ps_pcstk.sv - program-sequencer PC stack (PCSTK/PCSTKP); sticky ovf/unf built only with PS_PCSTK_ERR_EN
module ps_pcstk
    import ps_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic         clk,
    input  logic         rst,
    ps_pcstk_if.slave    bus
);

    localparam int PTRW = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTRW-1:0] SP_MAX = PTRW'(DEPTH);

    logic [PTRW-1:0] sp;
    logic [PTRW-1:0] sp_n;
    logic [PTRW-1:0] sp_m1;
    logic [PTRW-1:0] wr_sp;
    logic            psh_q;
    logic            at_pcstk_w;
    logic            upush;
    logic            uwr;
    logic            pwr;
    logic            push;
    logic            pop;
    logic [DW-1:0]   push_dat;
    logic            mem_we;
    logic [AW-1:0]   mem_wadr;
    logic [DW-1:0]   mem_wdat;
    logic [DW-1:0]   mem_rdat;
    logic [DW-1:0]   top;

`ifdef PS_PCSTK_ERR_EN
    logic ovf_q;
    logic unf_q;
    logic ovf_set;
    logic unf_set;
    logic flg_clr;
`endif

    assign sp_m1      = sp - PTRW'(1);
    assign wr_sp      = bus.ps_wrt_dat[PTRW-1:0];
    assign at_pcstk_w = bus.ps_wrt_en && (bus.ps_wrt_add == PCSTK);
    assign upush      = at_pcstk_w && psh_q;
    assign uwr        = at_pcstk_w && !psh_q;
    assign pwr        = bus.ps_wrt_en && (bus.ps_wrt_add == PCSTKP);
    assign push       = upush || bus.ps_sq_push;
    assign pop        = (bus.ps_popstck && (bus.ps_rd_add == PCSTK)) || bus.ps_sq_pop;
    // Sequencer CALL beats a coincident ureg push; only one entry is written.
    assign push_dat   = bus.ps_sq_push ? bus.ps_sq_pc : bus.ps_wrt_dat;

    always_comb begin
        sp_n     = sp;
        mem_we   = 1'b0;
        mem_wadr = sp[AW-1:0];
        mem_wdat = push_dat;
`ifdef PS_PCSTK_ERR_EN
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        flg_clr  = 1'b0;
`endif
        if (pwr) begin
            sp_n = (wr_sp > SP_MAX) ? SP_MAX : wr_sp;
`ifdef PS_PCSTK_ERR_EN
            flg_clr = 1'b1;
`endif
        end else if (push && pop) begin
            mem_we = 1'b1;
            if (sp != '0) begin
                mem_wadr = sp_m1[AW-1:0];
            end else begin
                mem_wadr = '0;
                sp_n     = PTRW'(1);
`ifdef PS_PCSTK_ERR_EN
                unf_set  = 1'b1;
`endif
            end
        end else if (push) begin
            if (sp != SP_MAX) begin
                mem_we = 1'b1;
                sp_n   = sp + PTRW'(1);
            end else begin
`ifdef PS_PCSTK_ERR_EN
                ovf_set = 1'b1;
`endif
            end
        end else if (pop) begin
            if (sp != '0) begin
                sp_n = sp_m1;
            end else begin
`ifdef PS_PCSTK_ERR_EN
                unf_set = 1'b1;
`endif
            end
        end else if (uwr) begin
            mem_we   = 1'b1;
            mem_wdat = bus.ps_wrt_dat;
            // Overwriting an empty stack has nothing to replace, so it becomes a push.
            if (sp != '0) begin
                mem_wadr = sp_m1[AW-1:0];
            end else begin
                mem_wadr = '0;
                sp_n     = PTRW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            psh_q <= 1'b0;
        end else begin
            sp    <= sp_n;
            psh_q <= bus.ps_pshstck;
        end
    end

`ifdef PS_PCSTK_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (flg_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q || ovf_set;
            unf_q <= unf_q || unf_set;
        end
    end

    assign bus.ps_stk_ovf = ovf_q;
    assign bus.ps_stk_unf = unf_q;
`else
    assign bus.ps_stk_ovf = 1'b0;
    assign bus.ps_stk_unf = 1'b0;
`endif

    ps_pcstk_mem #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .wadr  (mem_wadr),
        .wdat  (mem_wdat),
        .radr  (sp_m1[AW-1:0]),
        .rdat  (mem_rdat)
    );

    assign top              = (sp == '0) ? '0 : mem_rdat;
    assign bus.ps_stk_top   = top;
    assign bus.ps_stk_empty = (sp == '0);
    assign bus.ps_stk_full  = (sp == SP_MAX);

    always_comb begin
        bus.ps_rd_dat = '0;
        case (bus.ps_rd_add)
            PCSTK:   bus.ps_rd_dat = top;
            PCSTKP:  bus.ps_rd_dat = DW'(sp);
            default: bus.ps_rd_dat = '0;
        endcase
    end

endmodule

// File: tb/tb_ps_pcstk.sv
// tb/tb_ps_pcstk.sv - scoreboard bench for ps_pcstk
module tb_ps_pcstk;
    import ps_pkg::*;

`ifdef PS_PCSTK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [15:0] rd;
        logic [15:0] top;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ps_pcstk_if #(.DW(16)) bus ();

    ps_pcstk #(.DEPTH(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s.%s: got %h want %h", nm, fld, act, want);
        end
    endtask

    // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "rd_dat", bus.ps_rd_dat, e.rd);
            cmp(e.name, "top",    bus.ps_stk_top, e.top);
            cmp(e.name, "empty",  16'(bus.ps_stk_empty), 16'(e.empty));
            cmp(e.name, "full",   16'(bus.ps_stk_full),  16'(e.full));
            cmp(e.name, "ovf",    16'(bus.ps_stk_ovf),   16'(e.ovf));
            cmp(e.name, "unf",    16'(bus.ps_stk_unf),   16'(e.unf));
        end
    end

    task automatic idle();
        bus.ps_pshstck = 1'b0;
        bus.ps_popstck = 1'b0;
        bus.ps_rd_add  = PCSTKP;
        bus.ps_wrt_en  = 1'b0;
        bus.ps_wrt_add = 5'h00;
        bus.ps_wrt_dat = 16'h0000;
        bus.ps_sq_push = 1'b0;
        bus.ps_sq_pc   = 16'h0000;
        bus.ps_sq_pop  = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic uwrite(input logic [4:0] adr, input logic [15:0] dat);
        bus.ps_wrt_en  = 1'b1;
        bus.ps_wrt_add = adr;
        bus.ps_wrt_dat = dat;
    endtask

    task automatic expect_st(input string nm, input logic [15:0] rd, input logic [15:0] top,
                             input bit e, input bit f, input bit o, input bit u);
        exp_t x;
        x.name  = nm;
        x.rd    = rd;
        x.top   = top;
        x.empty = e;
        x.full  = f;
        x.ovf   = o && ERR_EN;
        x.unf   = u && ERR_EN;
        exp_q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        #1;
        expect_st("in_reset", 16'h0, 16'h0, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_st("after_reset", 16'h0, 16'h0, 1, 0, 0, 0);

        cyc(); bus.ps_sq_push = 1'b1; bus.ps_sq_pc = 16'h0123;
        cyc(); expect_st("sq_push", 16'd1, 16'h0123, 0, 0, 0, 0);

        cyc(); bus.ps_pshstck = 1'b1;
        cyc(); uwrite(PCSTK, 16'hBEEF);
        cyc(); expect_st("upush", 16'd2, 16'hBEEF, 0, 0, 0, 0);
        cyc(); bus.ps_popstck = 1'b1; bus.ps_rd_add = PCSTK;
        expect_st("pop_data", 16'hBEEF, 16'hBEEF, 0, 0, 0, 0);
        cyc(); expect_st("pop_sp", 16'd1, 16'h0123, 0, 0, 0, 0);

        for (int i = 2; i <= 16; i++) begin
            cyc(); bus.ps_sq_push = 1'b1; bus.ps_sq_pc = 16'(i);
        end
        cyc(); expect_st("fill", 16'd16, 16'h0010, 0, 1, 0, 0);
        cyc(); bus.ps_sq_push = 1'b1; bus.ps_sq_pc = 16'hFFFF;
        cyc(); expect_st("overflow", 16'd16, 16'h0010, 0, 1, 1, 0);
        cyc(); uwrite(PCSTKP, 16'h0003);
        cyc(); expect_st("pwr_sp3", 16'd3, 16'h0003, 0, 0, 0, 0);

        cyc(); uwrite(PCSTKP, 16'h0000);
        cyc(); bus.ps_popstck = 1'b1; bus.ps_rd_add = PCSTK;
        expect_st("pop_empty_data", 16'h0, 16'h0, 1, 0, 0, 0);
        cyc(); expect_st("underflow", 16'd0, 16'h0, 1, 0, 0, 1);
        cyc(); uwrite(PCSTKP, 16'h001F);
        cyc(); expect_st("pwr_clamp", 16'd16, 16'h0010, 0, 1, 0, 0);

        cyc(); uwrite(PCSTKP, 16'h0002);
        cyc(); bus.ps_sq_push = 1'b1; bus.ps_sq_pc = 16'h0400; bus.ps_sq_pop = 1'b1;
        cyc(); expect_st("push_pop", 16'd2, 16'h0400, 0, 0, 0, 0);

        cyc(); uwrite(PCSTKP, 16'h0000);
        cyc(); bus.ps_sq_push = 1'b1; bus.ps_sq_pc = 16'h0999; bus.ps_sq_pop = 1'b1;
        cyc(); expect_st("push_pop_empty", 16'd1, 16'h0999, 0, 0, 0, 1);

        cyc(); uwrite(PCSTKP, 16'h0000);
        cyc(); uwrite(PCSTK, 16'h0055);
        cyc(); expect_st("uwr_empty", 16'd1, 16'h0055, 0, 0, 0, 0);
        cyc(); uwrite(PCSTK, 16'h0077);
        cyc(); expect_st("uwr_top", 16'd1, 16'h0077, 0, 0, 0, 0);
        cyc(); bus.ps_rd_add = 5'h06;
        expect_st("rd_other", 16'h0, 16'h0077, 0, 0, 0, 0);

        cyc(); bus.ps_pshstck = 1'b1;
        cyc(); uwrite(PCSTK, 16'hAAAA); bus.ps_sq_push = 1'b1; bus.ps_sq_pc = 16'h0BBB;
        cyc(); expect_st("sq_wins", 16'd2, 16'h0BBB, 0, 0, 0, 0);
        cyc(); bus.ps_popstck = 1'b1; bus.ps_rd_add = PCSTK;
        expect_st("sq_wins_pop", 16'h0BBB, 16'h0BBB, 0, 0, 0, 0);
        cyc(); expect_st("sq_wins_below", 16'd1, 16'h0077, 0, 0, 0, 0);

        cyc();
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
